// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter for one router output port: pops the winning input FIFO and registers its flit onto the link.
// Optional per-requester grant and stall statistics are enabled with NOC_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no request pending
// SEND  | a flit was issued on the last edge
// STALL | requests pending but blocked by downstream backpressure
module noc_port_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 3,
    parameter int PTRW  = 2,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  dataIn,
    input  logic                   full_in,
    input  logic                   almost_full_in,
    output logic [NREQ-1:0]        read_out,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   writeOut,
    output logic [PTRW-1:0]        grant_id,
    output logic                   stall
`ifdef NOC_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [NREQ*CNTW-1:0]   grant_cnt,
    output logic [CNTW-1:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STALL
    } arbState_t;

    arbState_t       state;
    logic [PTRW-1:0] lastPtr;
    logic [PTRW-1:0] winner;
    logic            anyReq;
    logic            blk;
    logic            issue;

    function automatic logic [PTRW-1:0] pickWinner(input logic [NREQ-1:0] r,
                                                   input logic [PTRW-1:0] last);
        logic [PTRW-1:0] w;
        logic [NREQ-1:0] rs;
        logic            hit;
        int              idx;
        w   = '0;
        hit = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            rs  = r >> idx;
            if (!hit && rs[0]) begin
                w   = PTRW'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    // A write already on the link will take the last free downstream slot.
    assign anyReq = |req;
    assign blk    = full_in | (almost_full_in & writeOut);
    assign issue  = anyReq & ~blk;
    assign winner = pickWinner(req, lastPtr);

    always_comb begin
        read_out = '0;
        if (issue && reset)
            read_out = NREQ'(1) << winner;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lastPtr  <= PTRW'(NREQ - 1);
            dataOut  <= '0;
            writeOut <= 1'b0;
            grant_id <= '0;
            stall    <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (issue) state <= SEND;
                         else if (anyReq) state <= STALL;
                SEND:    if (issue) state <= SEND;
                         else if (anyReq) state <= STALL;
                         else state <= IDLE;
                STALL:   if (issue) state <= SEND;
                         else if (!anyReq) state <= IDLE;
                default: state <= IDLE;
            endcase
            stall <= anyReq & blk;
            if (issue) begin
                dataOut  <= dataIn[int'(winner)*WIDTH +: WIDTH];
                writeOut <= 1'b1;
                grant_id <= winner;
                lastPtr  <= winner;
            end else begin
                writeOut <= 1'b0;
            end
        end
    end

`ifdef NOC_ARB_STATS_EN
    // Counters saturate rather than wrap; a clear beats any same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else if (stats_clr) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue && grant_cnt[int'(winner)*CNTW +: CNTW] != '1)
                grant_cnt[int'(winner)*CNTW +: CNTW] <=
                    grant_cnt[int'(winner)*CNTW +: CNTW] + CNTW'(1);
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: directed and random cycles checked against a behavioural model of the port rules.
// Define NOC_ARB_STATS_EN to also exercise the statistics counters (built with 4-bit counters).
module tb_noc_port_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 3;
    localparam int PTRW  = 2;
`ifdef NOC_ARB_STATS_EN
    localparam int CNTW  = 4;
`else
    localparam int CNTW  = 16;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dataIn;
    logic                  full_in;
    logic                  almost_full_in;
    logic [NREQ-1:0]       read_out;
    logic [WIDTH-1:0]      dataOut;
    logic                  writeOut;
    logic [PTRW-1:0]       grant_id;
    logic                  stall;
`ifdef NOC_ARB_STATS_EN
    logic                  stats_clr;
    logic [NREQ*CNTW-1:0]  grant_cnt;
    logic [CNTW-1:0]       stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          mLast;
    logic        mWrite;
    logic [15:0] mData;
    int          mGrant;
    logic        mStall;
    int          mGc[NREQ];
    int          mSc;

    noc_port_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .PTRW(PTRW), .CNTW(CNTW)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .dataIn(dataIn),
        .full_in(full_in),
        .almost_full_in(almost_full_in),
        .read_out(read_out),
        .dataOut(dataOut),
        .writeOut(writeOut),
        .grant_id(grant_id),
        .stall(stall)
`ifdef NOC_ARB_STATS_EN
        ,
        .stats_clr(stats_clr),
        .grant_cnt(grant_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic modelReset();
        mLast  = NREQ - 1;
        mWrite = 1'b0;
        mData  = '0;
        mGrant = 0;
        mStall = 1'b0;
        mSc    = 0;
        for (int i = 0; i < NREQ; i++) mGc[i] = 0;
    endtask

    task automatic checkRegs();
        check("writeOut", writeOut, mWrite);
        check("dataOut", dataOut, mData);
        check("grant_id", grant_id, mGrant);
        check("stall", stall, mStall);
`ifdef NOC_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check($sformatf("grant_cnt%0d", i), grant_cnt[i*CNTW +: CNTW], mGc[i]);
        check("stall_cnt", stall_cnt, mSc);
`endif
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic [2:0] r, input logic [47:0] d, input logic f, input logic af);
        logic       blk;
        int         w;
        logic [2:0] expRd;
        req = r; dataIn = d; full_in = f; almost_full_in = af;
        #1;
        blk   = f | (af & mWrite);
        w     = (r != 3'b000 && !blk) ? pick(r, mLast) : -1;
        expRd = (w >= 0) ? 3'(1 << w) : 3'b000;
        check("read_out", read_out, expRd);
        check("read_out_onehot", $onehot0(read_out), 1);
        @(posedge clk);
`ifdef NOC_ARB_STATS_EN
        if (stats_clr) begin
            for (int i = 0; i < NREQ; i++) mGc[i] = 0;
            mSc = 0;
        end else begin
            if (w >= 0 && mGc[w] < (1 << CNTW) - 1) mGc[w]++;
            if (mStall && mSc < (1 << CNTW) - 1) mSc++;
        end
`endif
        mStall = (r != 3'b000) & blk;
        if (w >= 0) begin
            mWrite = 1'b1;
            mData  = d[w*16 +: 16];
            mGrant = w;
            mLast  = w;
        end else begin
            mWrite = 1'b0;
        end
        #1;
        checkRegs();
        @(negedge clk);
    endtask

    localparam logic [47:0] D123 = {16'h3333, 16'h2222, 16'h1111};

    initial begin
        logic [47:0] rd;
        reset = 1'b0; req = '0; dataIn = '0; full_in = 1'b0; almost_full_in = 1'b0;
`ifdef NOC_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkRegs();
        check("read_out_rst", read_out, 3'b000);
        reset = 1'b1;

        // All three requesting: round-robin 0,1,2,0,1,2
        for (int i = 0; i < 6; i++) cycle(3'b111, D123, 1'b0, 1'b0);
        // Single requester L
        for (int i = 0; i < 4; i++) cycle(3'b100, D123, 1'b0, 1'b0);
        // Full blocks E/W, then release
        for (int i = 0; i < 3; i++) cycle(3'b011, D123, 1'b1, 1'b0);
        cycle(3'b011, D123, 1'b0, 1'b0);
        cycle(3'b000, D123, 1'b0, 1'b0);
        // Almost-full: one issue, then blocked while the write sits on the link
        cycle(3'b001, D123, 1'b0, 1'b1);
        cycle(3'b001, D123, 1'b0, 1'b1);
        cycle(3'b001, D123, 1'b0, 1'b0);
        cycle(3'b001, D123, 1'b1, 1'b1);

        // Mid-stream reset with a flit on the link
        cycle(3'b111, D123, 1'b0, 1'b0);
        cycle(3'b111, D123, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        modelReset();
        checkRegs();
        check("read_out_midrst", read_out, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        cycle(3'b110, D123, 1'b0, 1'b0);
        cycle(3'b110, D123, 1'b0, 1'b0);

`ifdef NOC_ARB_STATS_EN
        stats_clr = 1'b1;
        cycle(3'b000, D123, 1'b0, 1'b0);
        stats_clr = 1'b0;
        for (int i = 0; i < 12; i++) cycle(3'b111, D123, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(3'b011, D123, 1'b1, 1'b0);
        cycle(3'b000, D123, 1'b0, 1'b0);
        check("stats_grant_e", grant_cnt[0 +: CNTW], 4);
        check("stats_stall", stall_cnt, 6);
        stats_clr = 1'b1;
        cycle(3'b001, D123, 1'b0, 1'b0);
        stats_clr = 1'b0;
        for (int i = 0; i < 20; i++) cycle(3'b001, D123, 1'b0, 1'b0);
        check("stats_sat", grant_cnt[0 +: CNTW], 15);
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            rd[31:0]  = $urandom;
            rd[47:32] = 16'($urandom);
`ifdef NOC_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            cycle(3'($urandom_range(0, 7)), rd,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
        end
`ifdef NOC_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Round-robin output-port arbiter for one noc_router output (E, W or L).
- Shares the output among the router's input FIFOs (E, W, L heads) whose head flit routes to this port.
- Pops the winning FIFO, registers the flit onto the output link and honours downstream full/almost_full backpressure.
- One instance per router output; a ring of four routers uses 12 instances.

Parameters:
- WIDTH, 16, flit width in bits.
- NREQ, 3, number of requesters. Index 0=E, 1=W, 2=L.
- PTRW, 2, width of grant index; must satisfy 2^PTRW >= NREQ.
- CNTW, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- req  input  NREQ  req[i]=1: FIFO i is non-empty and its head flit targets this port.
- dataIn  input  NREQ*WIDTH  head flits, FWFT; slice i = dataIn[i*WIDTH +: WIDTH].
- full_in  input  1  downstream FIFO full.
- almost_full_in  input  1  downstream FIFO has exactly one free slot.
- read_out  output  NREQ  one-hot pop strobe to the granted FIFO; combinational.
- dataOut  output  WIDTH  registered flit to downstream.
- writeOut  output  1  registered write strobe to downstream.
- grant_id  output  PTRW  registered index of the last granted requester.
- stall  output  1  registered; 1 when any req was pending but blocked by backpressure.

Behaviour:
- Reset values: dataOut=0, writeOut=0, grant_id=0, stall=0, last pointer=NREQ-1 (requester 0 has highest priority first), FSM=IDLE. read_out=0 while reset is low.
- Blocked condition: blk = full_in | (almost_full_in & writeOut). A write already on the link consumes the last free slot.
- Issue condition: issue = |req & ~blk.
- Winner: first index i with req[i]=1, searching from last+1 upward and wrapping modulo NREQ.
- On issue in cycle t:
  - read_out[winner]=1 in cycle t.
  - At edge t+1: dataOut<=dataIn slice of winner, writeOut<=1, grant_id<=winner, last<=winner.
- Without issue: writeOut<=0 and dataOut holds its value. last is unchanged.
- Latency: 1 cycle from req to writeOut. Throughput is one flit per cycle when not blocked.
- FSM (observable through stall and writeOut):
  - IDLE: no req. Goes to SEND on issue, or to STALL when req with blk.
  - SEND: a flit was issued last cycle. Stays in SEND on issue, goes to STALL on req with blk, goes to IDLE on no req.
  - STALL: stall=1. Goes to SEND on issue, to IDLE if req drops, otherwise stays.
- stall<=(|req & blk) each cycle.
- Fairness: with all requesters continuously asserting and no backpressure, grant order is 0,1,2,0,1,2...
- Single requester: granted every cycle and never starved.
- Request withdrawn in the same cycle it would win: no grant is made and last is unchanged.
- full_in=1 blocks the output regardless of almost_full_in.
- almost_full_in=1 with writeOut=0 allows exactly one issue, then blocks the next cycle.
- Reset mid-operation: outputs clear immediately. An in-flight registered flit is dropped (writeOut forced to 0). Priority restarts at requester 0.
- A non-one-hot read_out is a design error and must never occur.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NREQ*CNTW): per-requester count of grants.
  - Adds output stall_cnt (CNTW): cycles with stall asserted.
  - Both counters saturate at all-ones (no wrap) and clear on reset.
  - Adds input stats_clr (1), a synchronous clear of all counters.
  - If stats_clr and an increment coincide, the clear wins.
- Undefined: these ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Reset low, then req=3'b111 for 6 cycles with dataIn E=0x1111, W=0x2222, L=0x3333 and no backpressure -> writeOut=1 from cycle 2; dataOut sequence 0x1111,0x2222,0x3333,0x1111,0x2222,0x3333; grant_id 0,1,2,0,1,2.
- req=3'b100 continuously -> read_out=3'b100 every cycle, writeOut held 1, grant_id=2.
- req=3'b011 with full_in=1 for 3 cycles, then 0 -> read_out=0 and stall=1 during full. The first grant after release goes to requester 0, and writeOut rises one cycle later.
- almost_full_in=1 held, req=3'b001 -> exactly one flit issued (writeOut pulse). The following cycle read_out=0 and stall=1, and issue resumes only when almost_full_in drops.
- Mid-stream reset with writeOut=1 -> writeOut, dataOut and grant_id are 0 immediately. After release with req=3'b110, the first grant is requester 1.
- With NOC_ARB_STATS_EN: 4 grants each to E/W/L plus 5 stall cycles -> grant_cnt 4,4,4 and stall_cnt=5. Pulsing stats_clr sets all to 0. With CNTW=4 and 20 grants to E, grant_cnt[0] saturates at 15.
